// File: rtl/dep_issue_scheduler.sv
// Out-of-order issue scheduler: circular buffer of bs slots with per-slot dependency vectors,
// oldest-first issue over a valid/ready handshake, completion wake-up and in-order retire.
module dep_issue_scheduler #(
    parameter  int bs = 32,
    localparam int IW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [IW-1:0] alloc_index,
    input  logic [0:bs-1] alloc_dept,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [IW-1:0] issue_index,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic          retire_valid,
    output logic [IW-1:0] retire_index,
    output logic [IW:0]   count,
    output logic          empty,
    output logic          full
);

    typedef enum logic [1:0] {FREE, WAIT, ISSUED, DONE} slot_state_e;

    localparam logic [IW:0] BS_CNT = (IW+1)'(bs);

    slot_state_e   state_q [bs];
    slot_state_e   state_d [bs];
    logic [0:bs-1] dep_q   [bs];
    logic [0:bs-1] dep_d   [bs];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [IW:0]   count_q, count_d;

    logic          alloc_fire;
    logic          issue_fire;
    logic          complete_fire;
    logic [0:bs-1] alloc_mask;
    logic [IW-1:0] scan_idx;

    assign alloc_ready   = (count_q != BS_CNT);
    assign alloc_index   = tail_q;
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign issue_fire    = issue_valid && issue_ready;
    assign complete_fire = complete_valid && (state_q[complete_index] == ISSUED);
    assign retire_valid  = (state_q[head_q] == DONE);
    assign retire_index  = head_q;
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == BS_CNT);

    // Scanning from head means a stalled pick only changes when an older entry wakes up.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        issue_valid = 1'b0;
        issue_index = '0;
        scan_idx    = head_q;
        for (int i = 0; i < bs; i++) begin
            scan_idx = head_q + IW'(i);
            if (!issue_valid && state_q[scan_idx] == WAIT && dep_q[scan_idx] == '0) begin
                issue_valid = 1'b1;
                issue_index = scan_idx;
            end
        end
    end

    // Rows for FREE/DONE slots are stale in the relation table, and a same-cycle completion
    // would otherwise be lost because the new vector is written over the clearing.
    always_comb begin
        for (int j = 0; j < bs; j++) begin
            alloc_mask[j] = !(state_q[j] == FREE || state_q[j] == DONE);
        end
        alloc_mask[tail_q] = 1'b0;
        if (complete_fire) alloc_mask[complete_index] = 1'b0;
    end

    // Alloc, issue, complete and retire always touch slots in different states, hence distinct slots.
    always_comb begin
        for (int i = 0; i < bs; i++) begin
            state_d[i] = state_q[i];
            dep_d[i]   = dep_q[i];
            if (complete_fire) dep_d[i][complete_index] = 1'b0;
        end
        if (issue_fire)    state_d[issue_index]    = ISSUED;
        if (complete_fire) state_d[complete_index] = DONE;
        if (retire_valid) begin
            state_d[head_q] = FREE;
            dep_d[head_q]   = '0;
        end
        if (alloc_fire) begin
            state_d[tail_q] = WAIT;
            dep_d[tail_q]   = alloc_dept & alloc_mask;
        end
        head_d  = head_q + IW'(retire_valid);
        tail_d  = tail_q + IW'(alloc_fire);
        count_d = count_q + (IW+1)'(alloc_fire) - (IW+1)'(retire_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot array is reset on purpose; a stale WAIT or ISSUED slot would issue or retire garbage after reset.
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= FREE;
                dep_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Directed bench for dep_issue_scheduler (bs=4): hand-computed expectations per cycle.
module tb_dep_issue_scheduler;

    localparam int BS = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic [IW-1:0] alloc_index;
    logic [0:BS-1] alloc_dept = '0;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [IW-1:0] issue_index;
    logic          complete_valid = 1'b0;
    logic [IW-1:0] complete_index = '0;
    logic          retire_valid;
    logic [IW-1:0] retire_index;
    logic [IW:0]   count;
    logic          empty;
    logic          full;

    int checks   = 0;
    int failures = 0;

    dep_issue_scheduler #(.bs(BS)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_index    (alloc_index),
        .alloc_dept     (alloc_dept),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_index    (issue_index),
        .complete_valid (complete_valid),
        .complete_index (complete_index),
        .retire_valid   (retire_valid),
        .retire_index   (retire_index),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [0:BS-1] dept, input logic ir,
                         input logic cv, input logic [IW-1:0] ci);
        alloc_valid    = av;
        alloc_dept     = dept;
        issue_ready    = ir;
        complete_valid = cv;
        complete_index = ci;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},       count,        0);
        check({tag, "_empty"},       empty,        1);
        check({tag, "_full"},        full,         0);
        check({tag, "_alloc_ready"}, alloc_ready,  1);
        check({tag, "_alloc_index"}, alloc_index,  0);
        check({tag, "_issue_valid"}, issue_valid,  0);
        check({tag, "_retire_valid"},retire_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check_reset_state("rst0");
        rst = 1'b0;
        step();

        // Independent stream: issues 0,1,2 back to back, retires in order
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); check("ind_ai0", alloc_index, 0); step();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); check("ind_iv0", issue_valid, 1); check("ind_ii0", issue_index, 0); step();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0); check("ind_ii1", issue_index, 1); check("ind_cnt2", count, 2); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1); check("ind_ii2", issue_index, 2); check("ind_rv0", retire_valid, 1);
                                                 check("ind_ri0", retire_index, 0); check("ind_cnt3", count, 3); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2); check("ind_iv_none", issue_valid, 0); check("ind_ri1", retire_index, 1);
                                                 check("ind_rv1", retire_valid, 1); step();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0); check("ind_rv2", retire_valid, 1); check("ind_ri2", retire_index, 2); step();
        check("ind_cnt0", count, 0); check("ind_empty", empty, 1); check("ind_rv_end", retire_valid, 0);

        // RAW chain: slot1 waits on slot0
        do_reset();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); step();
        drive(1'b1, 4'b1000, 1'b1, 1'b0, 2'd0); check("raw_ii0", issue_index, 0); check("raw_iv0", issue_valid, 1); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0); check("raw_blocked", issue_valid, 0); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0); check("raw_iv1", issue_valid, 1); check("raw_ii1", issue_index, 1);
                                                 check("raw_rv0", retire_valid, 1); check("raw_ri0", retire_index, 0); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1); check("raw_rv_wait", retire_valid, 0); step();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0); check("raw_rv1", retire_valid, 1); check("raw_ri1", retire_index, 1); step();
        check("raw_empty", empty, 1);

        // Out-of-order issue, in-order retire
        do_reset();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); step();
        drive(1'b1, 4'b1000, 1'b1, 1'b0, 2'd0); check("ooo_ii0", issue_index, 0); step();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); check("ooo_iv_none", issue_valid, 0); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0); check("ooo_iv2", issue_valid, 1); check("ooo_ii2", issue_index, 2); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2); check("ooo_iv_none2", issue_valid, 0); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0); check("ooo_no_retire", retire_valid, 0); check("ooo_cnt3", count, 3); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0); check("ooo_rv0", retire_valid, 1); check("ooo_ri0", retire_index, 0);
                                                 check("ooo_iv1", issue_valid, 1); check("ooo_ii1", issue_index, 1); step();
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1); check("ooo_rv_wait1", retire_valid, 0); step();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0); check("ooo_ri1", retire_index, 1); check("ooo_rv1", retire_valid, 1); step();
        check("ooo_ri2", retire_index, 2); check("ooo_rv2", retire_valid, 1); step();
        check("ooo_empty", empty, 1);

        // Full and wrap
        do_reset();
        for (int i = 0; i < BS; i++) begin
            drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
            check($sformatf("full_ai%0d", i), alloc_index, i);
            step();
        end
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0); check("full_flag", full, 1); check("full_ar", alloc_ready, 0);
                                                 check("full_cnt", count, 4); check("full_ai_wrap", alloc_index, 0);
                                                 check("full_ii_stall", issue_index, 0); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0); check("full_cnt_ign", count, 4); check("full_ii_hold", issue_index, 0); step();
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0); check("full_ii1", issue_index, 1); step();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0); check("full_rv0", retire_valid, 1); check("full_ri0", retire_index, 0);
                                                 check("full_ar_ret", alloc_ready, 0); step();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0); check("wrap_ar", alloc_ready, 1); check("wrap_ai0", alloc_index, 0);
                                                 check("wrap_cnt3", count, 3); step();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0); check("wrap_cnt4", count, 4); check("wrap_full", full, 1);
                                                 check("wrap_ai1", alloc_index, 1); check("wrap_ii_head", issue_index, 1);

        // Stale FREE slot and same-cycle completion masked out of a new vector
        do_reset();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); step();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0); step();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0); check("mask_ii2", issue_index, 2); check("mask_ri0", retire_index, 0);
                                                 check("mask_rv0", retire_valid, 1); step();
        drive(1'b1, 4'b1011, 1'b1, 1'b1, 2'd2); check("mask_iv_none", issue_valid, 0); check("mask_ai3", alloc_index, 3); step();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0); check("mask_iv3", issue_valid, 1); check("mask_ii3", issue_index, 3);
                                                 check("mask_rv_none", retire_valid, 0); check("mask_cnt3", count, 3); step();

        // Reset mid-operation with ISSUED and DONE entries present
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        step();
        check_reset_state("rst_held");
        rst = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1); step();
        check("post_rst_cnt", count, 0); check("post_rst_rv", retire_valid, 0); check("post_rst_empty", empty, 1);
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0); step();
        check("post_rst_cnt1", count, 1); check("post_rst_ai1", alloc_index, 1); check("post_rst_iv", issue_valid, 1);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
